// File: rtl/uart_rx_ctrl.sv
// MiniUart receive controller: sample-tick generator, byte capture FSM with a
// small FIFO, and a DATA/STATUS/DIVISOR/CTRL register window with interrupt.
module uart_rx_ctrl #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned DIV_RST = 27
) (
    input  logic        clk,
    input  logic        rst,
    output logic        en_rx,
    input  logic [7:0]  rx_data,
    input  logic        rx_rs,
    output logic        over_read,
    input  logic [1:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    state_e               state_q;
    logic                 over_read_q;

    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     lim_m1;
    logic                 en_rx_q, en_rx_d;
    logic                 hit;

    logic                 rs_meta_q, rs_s_q;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 empty, full, push, pop, drop;

    logic                 overrun_q, overrun_d;
    logic                 rx_en_q, rx_en_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 wr_div, wr_ctrl;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata;

    assign wr_div  = we && (addr == REG_DIV);
    assign wr_ctrl = we && (addr == REG_CTRL);

    assign empty = (count_q == '0);
    assign full  = (count_q == (FIFO_AW + 1)'(DEPTH));
    // Full is judged before any same-cycle pop, so a capture into a full FIFO drops.
    assign push  = (state_q == CAPTURE) && !full;
    assign drop  = (state_q == CAPTURE) && full;
    assign pop   = re && (addr == REG_DATA) && !empty;

    // Divisor 0 behaves like 1: a tick every cycle.
    assign lim_m1 = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign hit    = (cnt_q == lim_m1);

    always_comb begin
        div_d     = wr_div ? wdata[DIV_W-1:0] : div_q;
        rx_en_d   = wr_ctrl ? wdata[0] : rx_en_q;
        irq_en_d  = wr_ctrl ? wdata[1] : irq_en_q;

        overrun_d = overrun_q;
        if (wr_ctrl && wdata[2]) overrun_d = 1'b0;
        if (drop)                overrun_d = 1'b1;

        en_rx_d = rx_en_q && rx_en_d && !wr_div && hit;
        if (!rx_en_d || wr_div || hit) cnt_d = '0;
        else                           cnt_d = cnt_q + DIV_W'(1);

        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);

        irq_d = irq_en_q && (!empty || overrun_q);

        rdata_d = rdata_q;
        if (re) begin
            case (addr)
                REG_DATA:   rdata_d = empty ? '0 : {24'b0, mem_q[rd_ptr_q]};
                REG_STATUS: rdata_d = {16'b0, 8'(count_q), 4'b0,
                                       rs_s_q, overrun_q, full, !empty};
                REG_DIV:    rdata_d = 32'(div_q);
                default:    rdata_d = {29'b0, 1'b0, irq_en_q, rx_en_q};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= DIV_W'(DIV_RST);
            cnt_q     <= '0;
            en_rx_q   <= 1'b0;
            rs_meta_q <= 1'b0;
            rs_s_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rx_en_q   <= 1'b1;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            en_rx_q   <= en_rx_d;
            rs_meta_q <= rx_rs;
            rs_s_q    <= rs_meta_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rx_en_q   <= rx_en_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    // WAIT_LOW holds off re-capture until the receiver has dropped its status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            over_read_q <= 1'b0;
        end else begin
            over_read_q <= 1'b0;
            case (state_q)
                IDLE:     if (rs_s_q) state_q <= CAPTURE;
                CAPTURE: begin
                    state_q     <= CLEAR;
                    over_read_q <= 1'b1;
                end
                CLEAR:    state_q <= WAIT_LOW;
                WAIT_LOW: if (!rs_s_q) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign en_rx     = en_rx_q;
    assign over_read = over_read_q;
    assign rdata     = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: bus-level stimulus with a byte scoreboard that models
// FIFO capacity and overrun, plus tick-timing and reset checks.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_rx;
    logic [7:0]  rx_data;
    logic        rx_rs;
    logic        over_read;
    logic [1:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    int or_pulses = 0;

    logic [7:0] sb[$];
    logic       model_ovr;

    uart_rx_ctrl #(.DIV_W(16), .FIFO_AW(2), .DIV_RST(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_rx     (en_rx),
        .rx_data   (rx_data),
        .rx_rs     (rx_rs),
        .over_read (over_read),
        .addr      (addr),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (over_read === 1'b1) or_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
        d = rdata;
    endtask

    function automatic logic [31:0] status_exp();
        logic [7:0] c;
        c = 8'(sb.size());
        return {16'b0, c, 4'b0, 1'b0, model_ovr, (sb.size() == 4), (sb.size() != 0)};
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_rd(2'd1, d);
        check(tag, d, status_exp());
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        bus_rd(2'd0, d);
        e = (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'h0;
        check(tag, d, e);
    endtask

    task automatic wait_clear(input int hold);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = over_read;
        end
        check("over_read_seen", 32'(seen), 32'h1);
        repeat (1 + hold) @(posedge clk);
        #1 rx_rs = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic deliver(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_rs   = 1'b1;
        if (sb.size() < 4) sb.push_back(b);
        else model_ovr = 1'b1;
        wait_clear(hold);
    endtask

    initial begin
        logic [31:0] d;
        int pulses, first, prev, bad, p0;

        rst = 1'b1; rx_data = '0; rx_rs = 1'b0; addr = '0;
        re = 1'b0; we = 1'b0; wdata = '0; model_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en_rx", 32'(en_rx), 32'h0);
        check("rst_over_read", 32'(over_read), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        bus_rd(2'd2, d); check("rst_divisor", d, 32'd27);
        bus_rd(2'd3, d); check("rst_ctrl", d, 32'h1);
        check_status("rst_status");

        // Sample tick, divisor 4
        bus_wr(2'd2, 32'd4);
        pulses = 0; first = 0; prev = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (en_rx) begin
                if (first == 0) first = i;
                if (prev != 0 && i - prev != 4) bad++;
                prev = i;
                pulses++;
            end
        end
        check("tick4_first", 32'(first), 32'd4);
        check("tick4_count", 32'(pulses), 32'd10);
        check("tick4_spacing", 32'(bad), 32'd0);
        bus_rd(2'd2, d); check("div_readback", d, 32'd4);

        bus_wr(2'd3, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (en_rx) pulses++;
        end
        check("tick_disabled", 32'(pulses), 32'd0);

        bus_wr(2'd3, 32'h1);
        bus_wr(2'd2, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (en_rx) pulses++;
        end
        check("tick0_every_cycle", 32'(pulses), 32'd10);
        bus_wr(2'd2, 32'd27);

        // Single byte
        p0 = or_pulses;
        deliver(8'hA5, 0);
        check("single_pulses", 32'(or_pulses - p0), 32'd1);
        check_status("single_status");
        read_data("single_data");
        check_status("single_status_empty");

        // Overrun: five bytes, four slots
        p0 = or_pulses;
        for (int i = 1; i <= 5; i++) deliver(8'(i), 0);
        check("ovr_pulses", 32'(or_pulses - p0), 32'd5);
        check_status("ovr_status");
        for (int i = 0; i < 4; i++) read_data("ovr_data");
        check_status("ovr_status_drained");
        bus_wr(2'd3, 32'h5);
        model_ovr = 1'b0;
        check_status("ovr_cleared");

        // Long rx_rs hold after clear
        p0 = or_pulses;
        deliver(8'h3C, 20);
        check("hold_pulses", 32'(or_pulses - p0), 32'd1);
        check_status("hold_status");
        read_data("hold_data");

        // DATA read coincident with capture
        deliver(8'h11, 0);
        deliver(8'h22, 0);
        rx_data = 8'h33;
        rx_rs   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_rd(2'd0, d);
        check("coincide_over_read", 32'(over_read), 32'h1);
        check("coincide_data", d, {24'b0, sb.pop_front()});
        sb.push_back(8'h33);
        @(posedge clk);
        #1 rx_rs = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_status("coincide_status");
        read_data("coincide_data2");
        read_data("coincide_data3");

        // Interrupt
        bus_wr(2'd3, 32'h3);
        @(posedge clk); #1;
        check("irq_idle", 32'(irq), 32'h0);
        deliver(8'h5A, 0);
        check("irq_raised", 32'(irq), 32'h1);
        read_data("irq_data");
        check("irq_hold_after_read", 32'(irq), 32'h1);
        @(posedge clk); #1;
        check("irq_fell", 32'(irq), 32'h0);

        // Reset while in CLEAR
        rx_data = 8'h77;
        rx_rs   = 1'b1;
        for (int i = 0; i < 20 && !over_read; i++) begin
            @(posedge clk); #1;
        end
        check("rst_clear_seen", 32'(over_read), 32'h1);
        #2 rst = 1'b1;
        #1 check("rst_clear_drop", 32'(over_read), 32'h0);
        rx_rs = 1'b0;
        sb.delete();
        model_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst2_irq", 32'(irq), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_status("rst2_status");
        bus_rd(2'd3, d); check("rst2_ctrl", d, 32'h1);

        // rx_rs still high across reset gets captured afterwards
        rx_data = 8'h99;
        rx_rs   = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        p0 = or_pulses;
        sb.push_back(8'h99);
        wait_clear(0);
        check("post_rst_pulses", 32'(or_pulses - p0), 32'd1);
        read_data("post_rst_data");
        check_status("final_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
